// File: rtl/bwop_pkg.sv
// Shared types for the bitwise-op sequencer: op encodings and the queued command record.
// Latency: n/a (types only).
// Backpressure: n/a.
package bwop_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_SHL = 2'b11;

  // One command as presented to the combinational unit.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [4:0]  shamt;
    logic [15:0] addin;
    logic        sel;
  } bwop_cmd_t;

endpackage

// File: rtl/bwop_cmd_fifo.sv
// Synchronous FIFO of bwop_cmd_t plus an opaque tag.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: push ignored while full (full flag is registered); pop ignored while empty.
// Ports: clk, rst_n | push, push_cmd, push_tag | pop, head_cmd, head_tag | full, empty, level
module bwop_cmd_fifo
  import bwop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  bwop_cmd_t              push_cmd,
  input  logic [TAG_W-1:0]       push_tag,
  input  logic                   pop,
  output bwop_cmd_t              head_cmd,
  output logic [TAG_W-1:0]       head_tag,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full_q, full_d;
  logic        push_en, pop_en;

  bwop_cmd_t        mem_cmd_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];

  assign push_en = push && !full_q;
  assign pop_en  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    // Full flag computed from next pointers so it is a clean flop output;
    // a pop from a full FIFO therefore frees a slot only on the following cycle.
    full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_cmd_q[wr_ptr_q[AW-1:0]] <= push_cmd;
      mem_tag_q[wr_ptr_q[AW-1:0]] <= push_tag;
    end
  end

  assign head_cmd = mem_cmd_q[rd_ptr_q[AW-1:0]];
  assign head_tag = mem_tag_q[rd_ptr_q[AW-1:0]];
  assign full     = full_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign level    = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/bitwise_op_sequencer.sv
// Issue stage for the external combinational bitwise/adder unit: queues commands, feeds the unit
// from the queue head, registers its results into one output slot.
// Latency: command accepted at edge N into an empty queue with a free slot -> res_valid after edge N+1;
//          1 result/cycle sustained while res_ready=1.
// Backpressure: cmd_ready = queue not full (registered, no path from res_ready); res_ready=0 holds slot and queue.
// Ports: cmd_* in (valid/ready), alu_* out to unit / alu_*_res in from unit, res_* out (valid/ready), fifo_level.
// Optional: BWOP_SEQ_STATS_EN adds issue_count (wrapping) and stall_count (saturating) outputs.
module bitwise_op_sequencer
  import bwop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [31:0]            cmd_a,
  input  logic [31:0]            cmd_b,
  input  logic [1:0]             cmd_op,
  input  logic [4:0]             cmd_shamt,
  input  logic [15:0]            cmd_addin,
  input  logic                   cmd_sel,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [1:0]             alu_op,
  output logic [4:0]             alu_shamt,
  output logic [15:0]            alu_addin,
  output logic                   alu_sel,
  input  logic [31:0]            alu_bitwise_res,
  input  logic [31:0]            alu_adder_res,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_bitwise,
  output logic [31:0]            res_adder,
  output logic [TAG_W-1:0]       res_tag,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef BWOP_SEQ_STATS_EN
  ,
  output logic [31:0]            issue_count,
  output logic [31:0]            stall_count
`endif
);

  bwop_cmd_t        push_cmd;
  bwop_cmd_t        head_cmd;
  logic [TAG_W-1:0] head_tag;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             issue;

  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_bitwise_q, res_bitwise_d;
  logic [31:0]      res_adder_q, res_adder_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;

  assign push_cmd = '{a: cmd_a, b: cmd_b, op: cmd_op, shamt: cmd_shamt, addin: cmd_addin, sel: cmd_sel};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  // Slot is free when empty or being drained this edge.
  assign issue     = !fifo_empty && (!res_valid_q || res_ready);

  bwop_cmd_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_cmd (push_cmd),
    .push_tag (cmd_tag),
    .pop      (issue),
    .head_cmd (head_cmd),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Unit inputs are forced to zero when there is no head so the unit sees a quiet bus.
  assign alu_a     = fifo_empty ? 32'h0  : head_cmd.a;
  assign alu_b     = fifo_empty ? 32'h0  : head_cmd.b;
  assign alu_op    = fifo_empty ? OP_AND : head_cmd.op;
  assign alu_shamt = fifo_empty ? 5'h0   : head_cmd.shamt;
  assign alu_addin = fifo_empty ? 16'h0  : head_cmd.addin;
  assign alu_sel   = fifo_empty ? 1'b0   : head_cmd.sel;

  always_comb begin
    res_valid_d   = res_valid_q;
    res_bitwise_d = res_bitwise_q;
    res_adder_d   = res_adder_q;
    res_tag_d     = res_tag_q;
    if (issue) begin
      res_valid_d   = 1'b1;
      res_bitwise_d = alu_bitwise_res;
      res_adder_d   = alu_adder_res;
      res_tag_d     = head_tag;
    end else if (res_valid_q && res_ready) begin
      res_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q   <= 1'b0;
      res_bitwise_q <= '0;
      res_adder_q   <= '0;
      res_tag_q     <= '0;
    end else begin
      res_valid_q   <= res_valid_d;
      res_bitwise_q <= res_bitwise_d;
      res_adder_q   <= res_adder_d;
      res_tag_q     <= res_tag_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_bitwise = res_bitwise_q;
  assign res_adder   = res_adder_q;
  assign res_tag     = res_tag_q;

`ifdef BWOP_SEQ_STATS_EN
  logic [31:0] issue_count_q, issue_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    issue_count_d = issue_count_q;
    stall_count_d = stall_count_q;
    if (issue) issue_count_d = issue_count_q + 32'd1;
    // Stall counter saturates rather than wrapping so a long stall is never under-reported.
    if (res_valid_q && !res_ready && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      issue_count_q <= issue_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign issue_count = issue_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_bitwise_op_sequencer.sv
// Bench for bitwise_op_sequencer: directed vector table, multi-cycle corner sequences and
// a randomized stream scored against a queue-based reference model.
module tb_bitwise_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_shamt = '0;
  logic [15:0] cmd_addin = '0;
  logic        cmd_sel = 1'b0;
  logic [3:0]  cmd_tag = '0;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [15:0] alu_addin;
  logic        alu_sel;
  logic [31:0] alu_bitwise_res, alu_adder_res;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_bitwise, res_adder;
  logic [3:0]  res_tag;
  logic [2:0]  fifo_level;
`ifdef BWOP_SEQ_STATS_EN
  logic [31:0] issue_count, stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Golden model of the external combinational unit.
  function automatic logic [31:0] unit_bw(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic [4:0] sh, input logic sel);
    if (sel) return a & b;
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return a << sh;
    endcase
  endfunction

  assign alu_bitwise_res = unit_bw(alu_a, alu_b, alu_op, alu_shamt, alu_sel);
  assign alu_adder_res   = alu_bitwise_res + {16'h0, alu_addin};

  bitwise_op_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_shamt(cmd_shamt),
    .cmd_addin(cmd_addin), .cmd_sel(cmd_sel), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
    .alu_addin(alu_addin), .alu_sel(alu_sel),
    .alu_bitwise_res(alu_bitwise_res), .alu_adder_res(alu_adder_res),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_bitwise(res_bitwise), .res_adder(res_adder), .res_tag(res_tag),
    .fifo_level(fifo_level)
`ifdef BWOP_SEQ_STATS_EN
    , .issue_count(issue_count), .stall_count(stall_count)
`endif
  );

  // Reference model: commands accepted but not yet consumed, oldest first.
  typedef struct {
    logic [31:0] bw;
    logic [31:0] ad;
    logic [3:0]  tag;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  op;
    logic [4:0]  sh;
    logic [15:0] addin;
    logic        sel;
    logic [3:0]  tag;
    logic [31:0] exp_bw, exp_ad;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic [3:0] tag);
    cmd_a     = $urandom;
    cmd_b     = $urandom;
    cmd_op    = 2'($urandom_range(3));
    cmd_shamt = 5'($urandom_range(31));
    cmd_addin = 16'($urandom_range(16'hFFFF));
    cmd_sel   = ($urandom_range(3) == 0);
    cmd_tag   = tag;
  endtask

  // One clock with scoreboarding of both handshakes, observed before the edge.
  task automatic cycle();
    exp_t e;
    chk("inflight", 64'(int'(fifo_level) + int'(res_valid)), 64'(q.size()));
    chk("cmd_ready_rule", 64'(cmd_ready), 64'(fifo_level != 3'd4));
    if (fifo_level == 3'd0)
      chk("alu_idle", {alu_a, alu_b, alu_op, alu_shamt, alu_addin, alu_sel}, 64'h0);
    if (cmd_valid && cmd_ready) begin
      e.bw  = unit_bw(cmd_a, cmd_b, cmd_op, cmd_shamt, cmd_sel);
      e.ad  = e.bw + {16'h0, cmd_addin};
      e.tag = cmd_tag;
      q.push_back(e);
    end
    if (res_valid && res_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 64'(res_tag), 64'hDEAD);
      end else begin
        e = q.pop_front();
        chk("res_bitwise", 64'(res_bitwise), 64'(e.bw));
        chk("res_adder", 64'(res_adder), 64'(e.ad));
        chk("res_tag", 64'(res_tag), 64'(e.tag));
      end
    end
    tick();
  endtask

  task automatic apply_reset();
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    q.delete();
  endtask

  task automatic drain(input string name);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 40 && (q.size() != 0 || res_valid); i++) cycle();
    chk(name, 64'(q.size()), 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    logic [31:0] saved_a;
    int n, results, first, gaps;

    vt[0] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'b00, 5'd0,  16'h0010, 1'b0, 4'h3, 32'h00F0_00F0, 32'h00F0_0100};
    vt[1] = '{32'h0000_0001, 32'h0000_0000, 2'b11, 5'd31, 16'h0000, 1'b0, 4'h5, 32'h8000_0000, 32'h8000_0000};
    vt[2] = '{32'h0000_0001, 32'h0000_0001, 2'b11, 5'd31, 16'h0000, 1'b1, 4'h6, 32'h0000_0001, 32'h0000_0001};
    vt[3] = '{32'h1234_0000, 32'h0000_5678, 2'b01, 5'd0,  16'hFFFF, 1'b0, 4'hA, 32'h1234_5678, 32'h1235_5677};
    vt[4] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 2'b10, 5'd0,  16'h0001, 1'b0, 4'hF, 32'hFFFF_0000, 32'hFFFF_0001};
    vt[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 2'b10, 5'd0,  16'h0001, 1'b0, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[6] = '{32'hDEAD_BEEF, 32'h0000_0000, 2'b11, 5'd4,  16'h0010, 1'b0, 4'h7, 32'hEADB_EEF0, 32'hEADB_EF00};
    vt[7] = '{32'h0000_00FF, 32'h0000_000F, 2'b01, 5'd0,  16'h0001, 1'b1, 4'h9, 32'h0000_000F, 32'h0000_0010};

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
    chk("rst_res_valid", 64'(res_valid), 64'h0);
    chk("rst_res_data", {res_bitwise, res_adder}, 64'h0);
    chk("rst_res_tag", 64'(res_tag), 64'h0);
    chk("rst_fifo_level", 64'(fifo_level), 64'h0);
    chk("rst_alu", {alu_a, alu_b, alu_op, alu_shamt, alu_addin, alu_sel}, 64'h0);
`ifdef BWOP_SEQ_STATS_EN
    chk("rst_counters", {issue_count, stall_count}, 64'h0);
`endif
    apply_reset();

    // Directed vectors: single command, check exact latency and values.
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmd_a = vt[i].a; cmd_b = vt[i].b; cmd_op = vt[i].op; cmd_shamt = vt[i].sh;
      cmd_addin = vt[i].addin; cmd_sel = vt[i].sel; cmd_tag = vt[i].tag;
      cmd_valid = 1'b1;
      chk("vec_cmd_ready", 64'(cmd_ready), 64'h1);
      tick();
      cmd_valid = 1'b0;
      chk("vec_not_yet_valid", 64'(res_valid), 64'h0);
      chk("vec_level1", 64'(fifo_level), 64'h1);
      tick();
      chk("vec_valid", 64'(res_valid), 64'h1);
      chk("vec_bitwise", 64'(res_bitwise), 64'(vt[i].exp_bw));
      chk("vec_adder", 64'(res_adder), 64'(vt[i].exp_ad));
      chk("vec_tag", 64'(res_tag), 64'(vt[i].tag));
      chk("vec_level0", 64'(fifo_level), 64'h0);
      tick();
      chk("vec_consumed", 64'(res_valid), 64'h0);
    end

    // Fill: slot + 4 queued with res_ready low, the next command must wait.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_rand(4'(i));
      cmd_valid = 1'b1;
      cycle();
    end
    chk("fill_res_valid", 64'(res_valid), 64'h1);
    chk("fill_slot_tag", 64'(res_tag), 64'h0);
    chk("fill_level", 64'(fifo_level), 64'h4);
    chk("fill_cmd_ready", 64'(cmd_ready), 64'h0);
    drive_rand(4'd5);
    saved_a = alu_a;
    cycle();
    cycle();
    chk("fill_hold_level", 64'(fifo_level), 64'h4);
    chk("fill_hold_alu", 64'(alu_a), 64'(saved_a));
    chk("fill_hold_tag", 64'(res_tag), 64'h0);
    res_ready = 1'b1;
    chk("full_issue_ready_low", 64'(cmd_ready), 64'h0);
    cycle();
    chk("full_ready_rises", 64'(cmd_ready), 64'h1);
    cycle();
    drain("fill_drain");

    // Random stream with constant res_ready: one result per cycle after the first.
    apply_reset();
    res_ready = 1'b1;
    n = 0; results = 0; first = -1; gaps = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic pushed;
      if (n < 100) begin
        drive_rand(4'(n));
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      pushed = cmd_valid && cmd_ready;
      if (res_valid) begin
        if (first < 0) first = cyc;
        results++;
      end else if (first >= 0 && results < 100) begin
        gaps++;
      end
      cycle();
      if (pushed) n++;
      if (n == 100 && q.size() == 0 && !res_valid) break;
    end
    chk("stream_first_cycle", 64'(first), 64'h2);
    chk("stream_gaps", 64'(gaps), 64'h0);
    chk("stream_results", 64'(results), 64'd100);

    // Random traffic on both sides.
    apply_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      drive_rand(4'($urandom_range(15)));
      cmd_valid = $urandom_range(1);
      res_ready = ($urandom_range(2) != 0);
      cycle();
    end
    drain("random_drain");

    // Asynchronous reset mid-stream with 3 queued behind a held result.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_rand(4'(i + 8));
      cmd_valid = 1'b1;
      cycle();
    end
    cmd_valid = 1'b0;
    chk("pre_rst_level", 64'(fifo_level), 64'h3);
    chk("pre_rst_valid", 64'(res_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(res_valid), 64'h0);
    chk("async_rst_level", 64'(fifo_level), 64'h0);
    chk("async_rst_ready", 64'(cmd_ready), 64'h1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("no_stale_result", 64'(res_valid), 64'h0);
      cycle();
    end

`ifdef BWOP_SEQ_STATS_EN
    // 10 issues with a free-running consumer, then 7 stalled cycles on the last result.
    apply_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_rand(4'(i));
      cmd_valid = 1'b1;
      cycle();
    end
    cmd_valid = 1'b0;
    cycle();
    res_ready = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    chk("issue_count", 64'(issue_count), 64'd10);
    chk("stall_count", 64'(stall_count), 64'd7);
    drain("stats_drain");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
